// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART echo bridge
package uart_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } parser_state_t;

    localparam logic [7:0] CMD_BYTE_DEFAULT = 8'h4C;

    // Width able to hold every occupancy value 0..depth inclusive
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word fall-through synchronous FIFO, power-of-two depth
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_WIDTH-1:0]         wdata,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          full,
    output logic                          empty,
    output logic [level_width(DEPTH)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = level_width(DEPTH);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count_q == LVL_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointers wrap for free because DEPTH is a power of two
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an empty count hides stale contents
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_echo_ctrl.sv
// rtl/uart_echo_ctrl.sv - buffered UART echo bridge with LED command parser
module uart_echo_ctrl
    import uart_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    DEPTH          = 16,
    parameter int                    LED_WIDTH      = 6,
    parameter bit                    LED_ACTIVE_LOW = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CMD_BYTE       = DATA_WIDTH'(CMD_BYTE_DEFAULT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    input  logic                          cmd_en,
    output logic [LED_WIDTH-1:0]          led,
    output logic [level_width(DEPTH)-1:0] fifo_level
);

    logic                          push;
    logic                          pop;
    logic                          full;
    logic                          empty;
    logic [level_width(DEPTH)-1:0] count;
    parser_state_t                 state_q, state_d;
    logic [LED_WIDTH-1:0]          led_reg_q, led_reg_d;

    assign s_axis_tready = !full && !rst;
    assign m_axis_tvalid = !empty && !rst;
    assign push          = s_axis_tvalid && s_axis_tready;
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign fifo_level    = count;
    assign led           = LED_ACTIVE_LOW ? ~led_reg_q : led_reg_q;

    sync_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .wdata(s_axis_tdata),
        .rdata(m_axis_tdata),
        .full (full),
        .empty(empty),
        .count(count)
    );

    // Parser only sees accepted bytes; echo path is unaffected by it
    always_comb begin
        state_d   = state_q;
        led_reg_d = led_reg_q;
        if (!cmd_en) begin
            state_d = IDLE;
            if (push) begin
                led_reg_d = s_axis_tdata[LED_WIDTH-1:0];
            end
        end else if (push) begin
            case (state_q)
                IDLE: begin
                    if (s_axis_tdata == CMD_BYTE) begin
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    led_reg_d = s_axis_tdata[LED_WIDTH-1:0];
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            led_reg_q <= '0;
        end else begin
            state_q   <= state_d;
            led_reg_q <= led_reg_d;
        end
    end

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// tb/tb_uart_echo_ctrl.sv - scoreboard bench for uart_echo_ctrl (DEPTH 16 and DEPTH 4 builds)
module tb_uart_echo_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_en = 1'b0;
    logic [7:0] s_tdata = '0;
    logic       s_tvalid = 1'b0;
    logic       s_tready;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready = 1'b0;
    logic [5:0] led;
    logic [4:0] fifo_level;

    logic [7:0] r_s_tdata = '0;
    logic       r_s_tvalid = 1'b0;
    logic       r_s_tready;
    logic [7:0] r_m_tdata;
    logic       r_m_tvalid;
    logic       r_m_tready = 1'b0;
    logic [5:0] r_led;
    logic [2:0] r_level;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [5:0] led_m = '0;
    bit         armed = 1'b0;

    always #5 clk = ~clk;

    uart_echo_ctrl dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .cmd_en(cmd_en), .led(led), .fifo_level(fifo_level)
    );

    uart_echo_ctrl #(.DEPTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(r_s_tdata), .s_axis_tvalid(r_s_tvalid), .s_axis_tready(r_s_tready),
        .m_axis_tdata(r_m_tdata), .m_axis_tvalid(r_m_tvalid), .m_axis_tready(r_m_tready),
        .cmd_en(cmd_en), .led(r_led), .fifo_level(r_level)
    );

    task automatic model_accept(input logic [7:0] b);
        if (!cmd_en || armed) begin
            led_m = b[5:0];
            armed = 1'b0;
        end else if (b == 8'h4C) begin
            armed = 1'b1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        bit ok = 1'b0;
        s_tdata  = b;
        s_tvalid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (s_tready) begin
                ok = 1'b1;
                exp_q.push_back(b);
                model_accept(b);
            end
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_timeout got s_tready=0 expected 1 for byte %0h", b);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (s_tready !== 1'b0) begin failures++; $display("FAIL rst_s_tready got %0b expected 0", s_tready); end
        checks++;
        if (m_tvalid !== 1'b0) begin failures++; $display("FAIL rst_m_tvalid got %0b expected 0", m_tvalid); end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete(); led_m = '0; armed = 1'b0;
        @(negedge clk);
        checks++;
        if (fifo_level !== 5'd0) begin failures++; $display("FAIL reset_level got %0d expected 0", fifo_level); end
        checks++;
        if (led !== 6'h3F) begin failures++; $display("FAIL reset_led got %0h expected 3f", led); end
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
            failures++; $display("FAIL reset_handshake got tvalid=%0b tready=%0b expected 0 1", m_tvalid, s_tready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_echo();
        cmd_en = 1'b0; m_tready = 1'b1;
        send(8'h35);
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 8'h35) begin
            failures++; $display("FAIL single_echo got tvalid=%0b data=%0h expected 1 35", m_tvalid, m_tdata);
        end
        checks++;
        if (led !== ~led_m || led !== 6'h0A) begin failures++; $display("FAIL single_led got %0h expected 0a", led); end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b0 || fifo_level !== 5'd0) begin
            failures++; $display("FAIL single_after got tvalid=%0b level=%0d expected 0 0", m_tvalid, fifo_level);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int n = 0;
        int popped = 0;
        bit pushed;
        cmd_en = 1'b0; m_tready = 1'b0;
        s_tdata = 8'h00; s_tvalid = 1'b1;
        for (int i = 0; i < 40 && n < 16; i++) begin
            @(negedge clk);
            pushed = s_tready;
            if (pushed) begin exp_q.push_back(s_tdata); model_accept(s_tdata); end
            @(posedge clk); #1;
            if (pushed) begin n++; s_tdata = 8'(n); end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (s_tready !== 1'b0) begin failures++; $display("FAIL full_tready got %0b expected 0", s_tready); end
        checks++;
        if (fifo_level !== 5'd16) begin failures++; $display("FAIL full_level got %0d expected 16", fifo_level); end
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 8'h00) begin
            failures++; $display("FAIL full_head got tvalid=%0b data=%0h expected 1 00", m_tvalid, m_tdata);
        end
        @(posedge clk); #1;
        m_tready = 1'b1;
        for (int i = 0; i < 80 && (exp_q.size() > 0 || s_tvalid); i++) begin
            @(negedge clk);
            pushed = s_tvalid && s_tready;
            if (m_tvalid) begin
                checks++;
                if (exp_q.size() == 0 || m_tdata !== exp_q[0]) begin
                    failures++;
                    $display("FAIL drain_data got %0h expected %0h", m_tdata, (exp_q.size() > 0) ? exp_q[0] : 8'hxx);
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                popped++;
            end
            if (pushed) begin exp_q.push_back(s_tdata); model_accept(s_tdata); end
            @(posedge clk); #1;
            if (pushed) s_tvalid = 1'b0;
        end
        checks++;
        if (popped != 17 || exp_q.size() != 0) begin
            failures++; $display("FAIL drain_count got %0d expected 17", popped);
        end
    endtask

    task automatic run_cmd_table(input string name, input logic [7:0] tbl[], input int drop_at);
        for (int i = 0; i < tbl.size(); i++) begin
            if (i == drop_at) begin
                cmd_en = 1'b0; armed = 1'b0;
                @(posedge clk); #1;
                cmd_en = 1'b1;
            end
            send(tbl[i]);
            @(negedge clk);
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== tbl[i]) begin
                failures++; $display("FAIL %s_echo[%0d] got %0h expected %0h", name, i, m_tdata, tbl[i]);
            end
            checks++;
            if (led !== ~led_m) begin
                failures++; $display("FAIL %s_led[%0d] got %0h expected %0h", name, i, led, ~led_m);
            end
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            @(posedge clk); #1;
        end
    endtask

    task automatic test_cmd_mode();
        logic [7:0] tbl[] = '{8'h41, 8'h4C, 8'h2A};
        cmd_en = 1'b1; m_tready = 1'b1;
        run_cmd_table("cmd", tbl, -1);
        checks++;
        if (led !== 6'h15) begin failures++; $display("FAIL cmd_final_led got %0h expected 15", led); end
    endtask

    task automatic test_double_cmd();
        logic [7:0] tbl[] = '{8'h4C, 8'h4C, 8'h01, 8'h4C, 8'h2B};
        cmd_en = 1'b1; m_tready = 1'b1;
        run_cmd_table("dbl", tbl, 4);
        checks++;
        if (led !== 6'h33) begin failures++; $display("FAIL dbl_final_led got %0h expected 33", led); end
    endtask

    task automatic test_reset_mid();
        cmd_en = 1'b0; m_tready = 1'b0;
        for (int i = 0; i < 5; i++) send(8'h50 + 8'(i));
        @(negedge clk);
        checks++;
        if (fifo_level !== 5'd5) begin failures++; $display("FAIL mid_level got %0d expected 5", fifo_level); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin
            failures++; $display("FAIL mid_rst_hs got tvalid=%0b tready=%0b expected 0 0", m_tvalid, s_tready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete(); led_m = '0; armed = 1'b0;
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b0 || fifo_level !== 5'd0 || led !== 6'h3F) begin
            failures++; $display("FAIL mid_after got tvalid=%0b level=%0d led=%0h expected 0 0 3f", m_tvalid, fifo_level, led);
        end
        @(posedge clk); #1;
        m_tready = 1'b1;
        send(8'h77);
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 8'h77 || led !== ~led_m) begin
            failures++; $display("FAIL mid_echo got data=%0h led=%0h expected 77 %0h", m_tdata, led, ~led_m);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        @(posedge clk); #1;
    endtask

    task automatic test_random_depth4();
        logic [7:0] rq[$];
        int  cnt = 0, sent = 0, rcvd = 0;
        bit  hold = 1'b0, push, pop;
        logic [7:0] held = '0;
        for (int cyc = 0; cyc < 20000 && rcvd < 1000; cyc++) begin
            if (!r_s_tvalid && sent < 1000 && $urandom_range(0, 1) == 1) begin
                r_s_tvalid = 1'b1;
                r_s_tdata  = 8'($urandom);
            end
            r_m_tready = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (r_level !== 3'(cnt) || cnt > 4) begin
                failures++; $display("FAIL rnd_level got %0d expected %0d", r_level, cnt);
            end
            checks++;
            if (r_s_tready !== (cnt != 4) || r_m_tvalid !== (cnt != 0)) begin
                failures++; $display("FAIL rnd_hs got tready=%0b tvalid=%0b expected level %0d", r_s_tready, r_m_tvalid, cnt);
            end
            if (hold) begin
                checks++;
                if (r_m_tvalid !== 1'b1 || r_m_tdata !== held) begin
                    failures++; $display("FAIL rnd_stable got %0h expected %0h", r_m_tdata, held);
                end
            end
            push = r_s_tvalid && r_s_tready;
            pop  = r_m_tvalid && r_m_tready;
            if (pop) begin
                checks++;
                if (rq.size() == 0 || r_m_tdata !== rq[0]) begin
                    failures++; $display("FAIL rnd_data got %0h expected %0h", r_m_tdata, (rq.size() > 0) ? rq[0] : 8'hxx);
                end
                if (rq.size() > 0) void'(rq.pop_front());
                rcvd++;
            end
            if (push) begin rq.push_back(r_s_tdata); sent++; end
            hold = r_m_tvalid && !r_m_tready;
            held = r_m_tdata;
            cnt  = cnt + int'(push) - int'(pop);
            @(posedge clk); #1;
            if (push) r_s_tvalid = 1'b0;
        end
        r_m_tready = 1'b0;
        checks++;
        if (rcvd != 1000) begin failures++; $display("FAIL rnd_total got %0d expected 1000", rcvd); end
    endtask

    initial begin
        test_reset();
        test_single_echo();
        test_backpressure();
        test_cmd_mode();
        test_double_cmd();
        test_reset_mid();
        test_random_depth4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
